shift_unit_arbiter: RTL
=======================

// Module: shift_unit_arbiter
// PURPOSE
//  Shares one combinational 32-bit shifter (SLL/SRL/SRA) between two requesters.
//  Requester 0 is the execute stage; requester 1 is the load/store byte-align unit.
//  Arbitration is round-robin. The result is registered and returned over a
//  valid/ready channel, tagged with the requester ID.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; fixed at 32, shift amount is 5 bits
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   synchronous reset, active-high
//  req0_valid  in   1   requester 0 has an operation
//  req0_ready  out  1   requester 0 operation accepted this cycle
//  req0_A      in   32  operand to shift
//  req0_B      in   5   shift amount
//  req0_op     in   2   Shiftop: 00 SLL, 10 SRL, 11 SRA, 01 reserved
//  req1_valid  in   1   requester 1, same semantics as req0_*
//  req1_ready  out  1
//  req1_A      in   32
//  req1_B      in   5
//  req1_op     in   2
//  rsp_valid   out  1   registered result available
//  rsp_ready   in   1   consumer accepts result
//  rsp_data    out  32  shifted result
//  rsp_id      out  1   requester that issued this result (0/1)
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (req0 wins first tie).
//    req*_ready=0 during the reset cycle.
//  - Output slot is one register. can_issue = !rsp_valid | rsp_ready.
//  - Grant (combinational, only when can_issue):
//    - only req0_valid -> grant 0
//    - only req1_valid -> grant 1
//    - both valid -> grant = ~last_grant
//  - reqN_ready = can_issue & grant==N. Never both high. A ready never depends on
//    that requester's own valid beyond the grant rule.
//  - Handshake: a transfer occurs when reqN_valid & reqN_ready. On that edge:
//    - rsp_data <= shift(A,B,op)
//    - rsp_id <= N
//    - rsp_valid <= 1
//    - last_grant <= N
//  - Latency: 1 cycle, request accept edge to rsp_valid. Throughput 1 op/cycle
//    while rsp_ready=1.
//  - rsp_valid & !rsp_ready: rsp_data and rsp_id hold stable. No request is accepted.
//  - rsp_valid & rsp_ready & no transfer: rsp_valid <= 0. rsp_data holds its last value.
//  - Simultaneous consume and new accept: rsp_valid stays 1 and the slot is
//    overwritten with the new result.
//  - Shift rules:
//    - SLL: A<<B
//    - SRL: A>>B, zero fill
//    - SRA: sign fill from A[31]
//    - op 01: result 32'h0, still returned with its rsp_id
//    - B=0 returns A for SLL, SRL and SRA.
//  - Requesters must hold valid and operands stable until ready. The block does
//    not register the inputs before the grant.
//  - Reset mid-operation: a pending result is dropped (rsp_valid=0) and
//    last_grant returns to 1.
//  - No starvation: with both requesters continuously valid and rsp_ready=1,
//    grants alternate 0,1,0,1...
// TESTING
//  1. Reset, then req0 SLL A=32'h0000_0001 B=31 with rsp_ready=1 -> 1 cycle later
//     rsp_valid=1, rsp_data=32'h8000_0000, rsp_id=0.
//  2. req1 SRA A=32'h8000_00F0 B=4 -> rsp_data=32'hF800_000F, rsp_id=1.
//     Same operands with SRL -> 32'h0800_000F.
//  3. Both valid for 4 ops each, rsp_ready=1 -> rsp_id sequence 0,1,0,1,...
//     One result per cycle, no bubbles.
//  4. rsp_ready=0 for 3 cycles with rsp_valid=1 -> rsp_data/rsp_id stable and
//     req*_ready=0. Release rsp_ready -> the next op is accepted the same cycle.
//  5. op=01 A=32'hFFFF_FFFF B=3 -> rsp_data=0. B=0 SRA A=32'h8000_0001 ->
//     32'h8000_0001.
//  6. Assert rst while rsp_valid=1 -> next cycle rsp_valid=0. With both valid
//     after reset, req0 is granted first.

Source files
------------

// File: rtl/shift_unit_arbiter_if.sv
// Request/response bundle for the shared shifter: two requesters in, one tagged result out.
// Handshake: a request moves when reqN_valid & reqN_ready on a rising edge; the result moves when
// rsp_valid & rsp_ready. A requester holds valid and operands stable until it sees ready.
interface shift_unit_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_A;
    logic [4:0]            req0_B;
    logic [1:0]            req0_op;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_A;
    logic [4:0]            req1_B;
    logic [1:0]            req1_op;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_id;

    modport master (
        output req0_valid, req0_A, req0_B, req0_op,
        output req1_valid, req1_A, req1_B, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_op,
        input  req1_valid, req1_A, req1_B, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/shift_unit_arbiter.sv
// One combinational SLL/SRL/SRA shifter shared round-robin between two requesters;
// the result sits in a single output register tagged with the requester id.
module shift_unit_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    shift_unit_arbiter_if.slave    bus
);
    logic                  last_grant;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_id_q;

    logic                  can_issue;
    logic                  grant;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [4:0]            sel_b;
    logic [1:0]            sel_op;
    logic [DATA_WIDTH-1:0] shift_res;

    // The slot may take a new result when empty or being drained this cycle.
    assign can_issue = !rsp_valid_q || bus.rsp_ready;

    // With a tie (or nobody asking) the side that did not win last time is favoured.
    always_comb begin
        grant = ~last_grant;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end
    end

    assign bus.req0_ready = !rst && can_issue && !grant;
    assign bus.req1_ready = !rst && can_issue && grant;

    assign xfer = grant ? (bus.req1_valid && bus.req1_ready)
                        : (bus.req0_valid && bus.req0_ready);

    always_comb begin
        sel_a  = bus.req0_A;
        sel_b  = bus.req0_B;
        sel_op = bus.req0_op;
        if (grant) begin
            sel_a  = bus.req1_A;
            sel_b  = bus.req1_B;
            sel_op = bus.req1_op;
        end
    end

    // Reserved op 01 still produces a response, carrying zero.
    always_comb begin
        shift_res = '0;
        case (sel_op)
            2'b00:   shift_res = sel_a << sel_b;
            2'b10:   shift_res = sel_a >> sel_b;
            2'b11:   shift_res = $signed(sel_a) >>> sel_b;
            default: shift_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            last_grant  <= 1'b1;
        end else if (xfer) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= shift_res;
            rsp_id_q    <= grant;
            last_grant  <= grant;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule
